booth_mult_seq: RTL and testbench

- Parametrised, self-sequenced radix-4 Booth multiplier: next generation of the ALU's multi-cycle 32-bit multiplier.
- Adds: configurable operand width; internal iteration counter, so no external counter input; start/ready/valid handshake; signed or unsigned mode per operation; full 2*WIDTH-bit product; registered overflow flag.
- Sits behind the execute-stage multdiv controller. The controller stalls on busy and captures the result on result_valid.

---
 rtl/booth_mult_seq_if.sv | 23 ++
 rtl/booth_mult_seq.sv | 111 +++++++++++
 tb/tb_booth_mult_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_seq_if.sv
// Handshake and result bundle for the sequential radix-4 Booth multiplier.
interface booth_mult_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             ready;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] product_lo;
  logic [WIDTH-1:0] product_hi;
  logic             overflow;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  ready, busy, result_valid, product_lo, product_hi, overflow
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output ready, busy, result_valid, product_lo, product_hi, overflow
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Self-sequenced radix-4 Booth multiplier: WIDTH/2+1 iterations per product,
// signed/unsigned per operation, full 2*WIDTH-bit result plus overflow flag.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  booth_mult_seq_if.slave  bus
);
  localparam int E  = WIDTH + 2;
  localparam int N  = E / 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;

  logic [E-1:0]     a_reg, acc, mplr;
  logic             guard, sgn;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p_lo, p_hi;
  logic             ovf, rv;
  logic             accept, last;

  logic [E:0]       a_x, addend, sum;
  logic [E-1:0]     acc_n, mplr_n;
  logic [2*WIDTH-1:0] prod;
  logic             ovf_n;

  assign accept = bus.start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(1));

  assign bus.ready        = (state == IDLE) || (state == DONE);
  assign bus.busy         = (state == RUN);
  assign bus.result_valid = rv;
  assign bus.product_lo   = p_lo;
  assign bus.product_hi   = p_hi;
  assign bus.overflow     = ovf;

  function automatic logic [E-1:0] ext(input logic [WIDTH-1:0] x, input logic s);
    return s ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
  endfunction

  // One Booth digit: add at E+1 bits so +/-2A cannot wrap, then shift by 2.
  always_comb begin
    a_x = {a_reg[E-1], a_reg};
    case ({mplr[1:0], guard})
      3'b001, 3'b010: addend = a_x;
      3'b011:         addend = {a_reg, 1'b0};
      3'b100:         addend = -{a_reg, 1'b0};
      3'b101, 3'b110: addend = -a_x;
      default:        addend = '0;
    endcase
    sum    = {acc[E-1], acc} + addend;
    acc_n  = {sum[E], sum[E:2]};
    mplr_n = {sum[1:0], mplr[E-1:2]};
    prod   = {acc_n[2*WIDTH-E-1:0], mplr_n};
    ovf_n  = sgn ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                 : (prod[2*WIDTH-1:WIDTH] != '0);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (cnt == CW'(1)) state_n = DONE;
      DONE:    state_n = bus.start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= '0;
      acc   <= '0;
      mplr  <= '0;
      guard <= 1'b0;
      sgn   <= 1'b0;
      cnt   <= '0;
      p_lo  <= '0;
      p_hi  <= '0;
      ovf   <= 1'b0;
      rv    <= 1'b0;
    end else begin
      rv <= 1'b0;
      if (accept) begin
        a_reg <= ext(bus.multiplicand, bus.is_signed);
        mplr  <= ext(bus.multiplier, bus.is_signed);
        acc   <= '0;
        guard <= 1'b0;
        sgn   <= bus.is_signed;
        cnt   <= CW'(N);
      end else if (state == RUN) begin
        acc   <= acc_n;
        mplr  <= mplr_n;
        guard <= mplr[1];
        cnt   <= cnt - CW'(1);
        if (last) begin
          p_lo <= prod[WIDTH-1:0];
          p_hi <= prod[2*WIDTH-1:WIDTH];
          ovf  <= ovf_n;
          rv   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench: driver pushes hand-computed products, per-instance
// monitors pop and compare value, overflow and arrival cycle on result_valid.
module tb_booth_mult_seq;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ov;
    int          due;
  } exp_t;

  logic clk, reset;
  int   cyc;
  int   checks, errors;
  exp_t q32[$];
  exp_t q8[$];

  booth_mult_seq_if #(.WIDTH(32)) if32();
  booth_mult_seq_if #(.WIDTH(8))  if8();

  booth_mult_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
  booth_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (if32.result_valid === 1'b1) begin
      if (q32.size() == 0) chk("w32_unexpected_valid", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q32.pop_front();
        chk("w32_lo", 64'(if32.product_lo), 64'(e.lo));
        chk("w32_hi", 64'(if32.product_hi), 64'(e.hi));
        chk("w32_ov", 64'(if32.overflow), 64'(e.ov));
        chk("w32_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    if (if8.result_valid === 1'b1) begin
      if (q8.size() == 0) chk("w8_unexpected_valid", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("w8_lo", 64'(if8.product_lo), 64'(e.lo[7:0]));
        chk("w8_hi", 64'(if8.product_hi), 64'(e.hi[7:0]));
        chk("w8_ov", 64'(if8.overflow), 64'(e.ov));
        chk("w8_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Caller is just after a negedge; the following posedge is the accept edge.
  task automatic go32(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] lo, input logic [31:0] hi, input logic ov);
    exp_t e;
    if32.is_signed = s; if32.multiplicand = a; if32.multiplier = b; if32.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if32.start = 1'b0;
    if32.multiplicand = ~a; if32.multiplier = ~b; if32.is_signed = ~s;
    e.lo = lo; e.hi = hi; e.ov = ov; e.due = cyc + 17;
    q32.push_back(e);
  endtask

  task automatic go8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] lo, input logic [7:0] hi, input logic ov);
    exp_t e;
    if8.is_signed = s; if8.multiplicand = a; if8.multiplier = b; if8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0;
    if8.multiplicand = ~a; if8.multiplier = ~b;
    e.lo = {24'd0, lo}; e.hi = {24'd0, hi}; e.ov = ov; e.due = cyc + 5;
    q8.push_back(e);
  endtask

  task automatic drain32();
    int n = 0;
    while (q32.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("w32_drain_timeout", 64'(q32.size()), 64'd0);
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("w8_drain_timeout", 64'(q8.size()), 64'd0);
  endtask

  initial begin
    int n;
    cyc = 0; checks = 0; errors = 0;
    reset = 1'b0;
    if32.start = 1'b0; if32.is_signed = 1'b0; if32.multiplicand = '0; if32.multiplier = '0;
    if8.start = 1'b0;  if8.is_signed = 1'b0;  if8.multiplicand = '0;  if8.multiplier = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", 64'(if32.ready), 64'd1);
    chk("rst_busy", 64'(if32.busy), 64'd0);
    chk("rst_valid", 64'(if32.result_valid), 64'd0);
    chk("rst_prod", {if32.product_hi, if32.product_lo}, 64'd0);
    chk("rst_ov", 64'(if32.overflow), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    go32(1'b1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
    chk("run_busy", 64'(if32.busy), 64'd1);
    chk("run_ready", 64'(if32.ready), 64'd0);
    drain32();
    @(negedge clk);
    go32(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1);
    drain32(); @(negedge clk);
    go32(1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b1);
    drain32(); @(negedge clk);
    go32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1);
    drain32(); @(negedge clk);
    go32(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    drain32(); @(negedge clk);
    go32(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h3FFFFFFF, 1'b1);
    drain32(); @(negedge clk);
    go32(1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1);
    drain32(); @(negedge clk);

    // Start during RUN must be ignored; start in DONE is taken back-to-back.
    go32(1'b1, 32'd5, 32'd6, 32'd30, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    if32.start = 1'b1; if32.is_signed = 1'b1; if32.multiplicand = 32'd9; if32.multiplier = 32'd9;
    @(negedge clk);
    if32.start = 1'b0;
    n = 0;
    while (if32.result_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("b2b_wait_valid", 64'(if32.result_valid), 64'd1);
    go32(1'b1, 32'd9, 32'd9, 32'd81, 32'd0, 1'b0);
    drain32(); @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    go32(1'b1, 32'h00001234, 32'h00005678, 32'h06260060, 32'h0, 1'b0);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    q32.delete();
    chk("midrst_ready", 64'(if32.ready), 64'd1);
    chk("midrst_busy", 64'(if32.busy), 64'd0);
    chk("midrst_valid", 64'(if32.result_valid), 64'd0);
    chk("midrst_prod", {if32.product_hi, if32.product_lo}, 64'd0);
    chk("midrst_ov", 64'(if32.overflow), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    go32(1'b1, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b1);
    drain32(); @(negedge clk);

    go8(1'b1, 8'h80, 8'h80, 8'h00, 8'h40, 1'b1);
    drain8(); @(negedge clk);
    go8(1'b1, 8'h7F, 8'h02, 8'hFE, 8'h00, 1'b1);
    drain8(); @(negedge clk);
    go8(1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1);
    drain8(); @(negedge clk);
    go8(1'b1, 8'hFF, 8'h03, 8'hFD, 8'hFF, 1'b0);
    drain8();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
